// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory: size encodings, FSM states,
// and the request bounds check.
package data_mem_pkg;

  localparam logic [1:0] SZ_BYTE_U = 2'b00;
  localparam logic [1:0] SZ_BYTE_S = 2'b01;
  localparam logic [1:0] SZ_HALF   = 2'b10;
  localparam logic [1:0] SZ_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LO,
    HI,
    RESP
  } state_t;

  // A halfword must have both bytes inside the array; nothing wraps around.
  function automatic logic bounds_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned depth);
    logic [32:0] last;
    last = {1'b0, addr} + ((size == SZ_HALF) ? 33'd1 : 33'd0);
    return (size == SZ_RSVD) || (last >= 33'(depth));
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response handshake bundle between the pipeline and the data memory.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_memory_ctrl_byte_ram.sv
// Byte-wide storage: synchronous write, combinational read so the controller
// can sample the addressed byte at the end of the same cycle.
module byte_ram #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked MEM-stage data memory: clears the array after reset, then serves
// one byte or little-endian halfword request at a time with bounds checking.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input logic          clk,
  input logic          reset,
  data_memory_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  state_t            state_q, state_d;
  logic [AW-1:0]     sweep_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [7:0]        lo_q, hi_q;

  logic              accept;
  logic              req_err;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign req_err = bounds_err(bus.req_size, 32'(bus.req_addr), DEPTH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: if (sweep_q == AW'(DEPTH - 1)) state_d = IDLE;
      IDLE: if (accept) state_d = req_err ? RESP : LO;
      LO:   state_d = (size_q == SZ_HALF) ? HI : RESP;
      HI:   state_d = RESP;
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_q <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE_U;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
    end else begin
      if (state_q == INIT) begin
        sweep_q <= sweep_q + AW'(1);
      end
      if (accept) begin
        we_q    <= bus.req_we;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr[AW-1:0];
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        lo_q    <= 8'h00;
        hi_q    <= 8'h00;
      end
      if (state_q == LO && !we_q) lo_q <= ram_rdata;
      if (state_q == HI && !we_q) hi_q <= ram_rdata;
    end
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    ram_we        = 1'b0;
    ram_addr      = addr_q;
    ram_wdata     = 8'h00;
    case (state_q)
      INIT: begin
        ram_we   = 1'b1;
        ram_addr = sweep_q;
      end
      LO: begin
        ram_we    = we_q;
        ram_wdata = wdata_q[7:0];
      end
      HI: begin
        ram_we    = we_q;
        ram_addr  = addr_q + AW'(1);
        ram_wdata = wdata_q[15:8];
      end
      RESP: begin
        bus.rsp_err = err_q;
        // Stores and rejected requests always answer with zero data.
        if (!err_q && !we_q) begin
          case (size_q)
            SZ_BYTE_U: bus.rsp_rdata = {8'h00, lo_q};
            SZ_BYTE_S: bus.rsp_rdata = {{8{lo_q[7]}}, lo_q};
            default:   bus.rsp_rdata = {hi_q, lo_q};
          endcase
        end
      end
      default: ;
    endcase
  end

  byte_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: reset sweep, byte/halfword access,
// extension, error rejection, backpressure and reset during an access.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  data_memory_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge right after reset is released.
  task automatic wait_sweep(output int cyc, output int stale);
    cyc = 0;
    stale = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.rsp_valid) stale++;
    end while (!bus.req_ready && cyc < 2000);
  endtask

  // Called at a negedge; returns at a negedge with the handshake complete.
  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic [15:0] addr, input logic [15:0] wdata, input int hold,
                        output logic [15:0] rdata, output logic err, output int lat);
    int waited = 0;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = (hold == 0);
    while (!bus.req_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check({tag, "_accept_timeout"}, 0, 1);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.rsp_valid) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      bus.rsp_ready = 1'b1;
      return;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, bus.rsp_valid, 1'b1);
      check({tag, "_hold_rdata"}, bus.rsp_rdata, rdata);
      check({tag, "_hold_ready"}, bus.req_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    $display("[TB] %s we=%0b size=%0d addr=%0d wdata=%h -> rdata=%h err=%0b lat=%0d",
             tag, we, size, addr, wdata, rdata, err, lat);
  endtask

  logic [15:0] rd;
  logic        er;
  int          lat, cyc, stale;

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 16'h0000);
    check("rst_rsp_err",   bus.rsp_err,   1'b0);
    reset = 1'b0;
    wait_sweep(cyc, stale);
    check("sweep1_cycles", cyc, 256);

    do_req("pre_st0",   1'b1, 2'b00, 16'd0,   16'h005A, 0, rd, er, lat);
    do_req("pre_st127", 1'b1, 2'b00, 16'd127, 16'h00A5, 0, rd, er, lat);
    do_req("pre_st255", 1'b1, 2'b00, 16'd255, 16'h0077, 0, rd, er, lat);
    do_req("pre_ld0",   1'b0, 2'b00, 16'd0,   16'h0000, 0, rd, er, lat);
    check("pre_ld0_data", rd, 16'h005A);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_sweep(cyc, stale);
    check("sweep2_cycles", cyc, 256);
    do_req("clr_ld0",   1'b0, 2'b00, 16'd0,   16'h0000, 0, rd, er, lat);
    check("clr_ld0_data", rd, 16'h0000);
    do_req("clr_ld127", 1'b0, 2'b00, 16'd127, 16'h0000, 0, rd, er, lat);
    check("clr_ld127_data", rd, 16'h0000);
    do_req("clr_ld255", 1'b0, 2'b00, 16'd255, 16'h0000, 0, rd, er, lat);
    check("clr_ld255_data", rd, 16'h0000);

    do_req("st_beef", 1'b1, 2'b10, 16'd10, 16'hBEEF, 0, rd, er, lat);
    check("st_beef_rdata", rd, 16'h0000);
    check("st_beef_err",   er, 1'b0);
    check("st_beef_lat",   lat, 3);
    do_req("ld_beef", 1'b0, 2'b10, 16'd10, 16'h0000, 0, rd, er, lat);
    check("ld_beef_data", rd, 16'hBEEF);
    check("ld_beef_lat",  lat, 3);
    do_req("ld_b10", 1'b0, 2'b00, 16'd10, 16'h0000, 0, rd, er, lat);
    check("ld_b10_data", rd, 16'h00EF);
    check("ld_b10_lat",  lat, 2);
    do_req("ld_b11", 1'b0, 2'b00, 16'd11, 16'h0000, 0, rd, er, lat);
    check("ld_b11_data", rd, 16'h00BE);

    do_req("st_85", 1'b1, 2'b00, 16'd3, 16'h1285, 0, rd, er, lat);
    check("st_85_lat", lat, 2);
    do_req("ld_u85", 1'b0, 2'b00, 16'd3, 16'h0000, 0, rd, er, lat);
    check("ld_u85_data", rd, 16'h0085);
    do_req("ld_s85", 1'b0, 2'b01, 16'd3, 16'h0000, 0, rd, er, lat);
    check("ld_s85_data", rd, 16'hFF85);
    check("ld_s85_lat",  lat, 2);
    do_req("ld_b4", 1'b0, 2'b01, 16'd4, 16'h0000, 0, rd, er, lat);
    check("ld_b4_above_store", rd, 16'h0000);

    do_req("err_h255", 1'b1, 2'b10, 16'd255, 16'hFFFF, 0, rd, er, lat);
    check("err_h255_err",   er, 1'b1);
    check("err_h255_rdata", rd, 16'h0000);
    check("err_h255_lat",   lat, 1);
    do_req("err_l256", 1'b0, 2'b00, 16'd256, 16'h0000, 0, rd, er, lat);
    check("err_l256_err",   er, 1'b1);
    check("err_l256_rdata", rd, 16'h0000);
    check("err_l256_lat",   lat, 1);
    do_req("err_sz3", 1'b1, 2'b11, 16'd5, 16'h00CC, 0, rd, er, lat);
    check("err_sz3_err", er, 1'b1);
    check("err_sz3_lat", lat, 1);
    do_req("err_sz3_ld", 1'b0, 2'b11, 16'd10, 16'h0000, 0, rd, er, lat);
    check("err_sz3_ld_rdata", rd, 16'h0000);
    do_req("chk_255", 1'b0, 2'b00, 16'd255, 16'h0000, 0, rd, er, lat);
    check("chk_255_unchanged", rd, 16'h0000);
    check("chk_255_err", er, 1'b0);
    do_req("chk_5", 1'b0, 2'b00, 16'd5, 16'h0000, 0, rd, er, lat);
    check("chk_5_unchanged", rd, 16'h0000);

    do_req("st_1234", 1'b1, 2'b10, 16'd40, 16'h1234, 0, rd, er, lat);
    do_req("bp_ld", 1'b0, 2'b10, 16'd40, 16'h0000, 5, rd, er, lat);
    check("bp_ld_data", rd, 16'h1234);
    check("bp_after_ready", bus.req_ready, 1'b1);
    do_req("bp_next", 1'b0, 2'b00, 16'd41, 16'h0000, 0, rd, er, lat);
    check("bp_next_data", rd, 16'h0012);
    check("bp_next_lat",  lat, 2);

    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 16'd20;
    bus.req_wdata = 16'hAAAA;
    check("midop_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midop_no_valid", bus.rsp_valid, 1'b0);
    wait_sweep(cyc, stale);
    check("midop_sweep_cycles", cyc, 256);
    check("midop_stale_valid", stale, 0);
    do_req("midop_ld20", 1'b0, 2'b10, 16'd20, 16'h0000, 0, rd, er, lat);
    check("midop_ld20_data", rd, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
